// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the two writeback sources and rf_wb_arbiter, plus the RF write port.
// Handshake: a transfer happens in any cycle where valid && ready; the source holds valid/addr/data stable until then.
interface rf_wb_arbiter_if;
    logic        i_s0_valid;
    logic        o_s0_ready;
    logic [4:0]  i_s0_addr;
    logic [31:0] i_s0_data;
    logic        i_s1_valid;
    logic        o_s1_ready;
    logic [4:0]  i_s1_addr;
    logic [31:0] i_s1_data;
    logic        i_hold;
    logic        o_rd_wen;
    logic [4:0]  o_rd_waddr;
    logic [31:0] o_rd_wdata;
    logic        o_busy;

    modport master (
        output i_s0_valid, i_s0_addr, i_s0_data,
        output i_s1_valid, i_s1_addr, i_s1_data,
        output i_hold,
        input  o_s0_ready, o_s1_ready,
        input  o_rd_wen, o_rd_waddr, o_rd_wdata, o_busy
    );

    modport slave (
        input  i_s0_valid, i_s0_addr, i_s0_data,
        input  i_s1_valid, i_s1_addr, i_s1_data,
        input  i_hold,
        output o_s0_ready, o_s1_ready,
        output o_rd_wen, o_rd_waddr, o_rd_wdata, o_busy
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Two-source register-file writeback arbiter with one registered output stage and a src1 starvation guard.
// Optional macro WB_ARB_RR_EN: round-robin priority instead of fixed src0 priority.
module rf_wb_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    rf_wb_arbiter_if.slave   wb,
    output logic [CNT_W-1:0] o_dbg_cnt,
    output logic             o_dbg_rr_ptr,
    output logic             o_dbg_stage
);

    typedef enum logic {
        STG_EMPTY = 1'b0,
        STG_FULL  = 1'b1
    } stage_e;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    stage_e           stage_q, stage_d;
    logic [4:0]       addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rr_ptr_q, rr_ptr_d;

    logic stage_free;
    logic starved;
    logic pick_s1;
    logic gnt0;
    logic gnt1;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stage_q  <= STG_EMPTY;
            addr_q   <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            rr_ptr_q <= 1'b0;
        end else begin
            stage_q  <= stage_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // The staged entry drains every unheld cycle, so the stage is free whenever hold is low.
    // Gating with reset keeps both readies low while reset is asserted.
    always_comb begin
        stage_free = i_rst_n && !wb.i_hold;
        starved    = (cnt_q == MAX_CNT);
`ifdef WB_ARB_RR_EN
        pick_s1    = wb.i_s1_valid && (!wb.i_s0_valid || starved || rr_ptr_q);
`else
        pick_s1    = wb.i_s1_valid && (!wb.i_s0_valid || starved);
`endif
        gnt1       = stage_free && pick_s1;
        gnt0       = stage_free && wb.i_s0_valid && !pick_s1;
    end

    // Next-state logic
    always_comb begin
        stage_d  = stage_q;
        addr_d   = addr_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        if (!wb.i_hold) begin
            if (gnt0) begin
                stage_d = STG_FULL;
                addr_d  = wb.i_s0_addr;
                data_d  = wb.i_s0_data;
            end else if (gnt1) begin
                stage_d = STG_FULL;
                addr_d  = wb.i_s1_addr;
                data_d  = wb.i_s1_data;
            end else begin
                stage_d = STG_EMPTY;
            end
        end
        // Held cycles still count as lost arbitration for a waiting src1.
        if (gnt1) begin
            cnt_d = '0;
        end else if (wb.i_s1_valid && !starved) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
`ifdef WB_ARB_RR_EN
        if (gnt0) begin
            rr_ptr_d = 1'b1;
        end else if (gnt1) begin
            rr_ptr_d = 1'b0;
        end
`else
        rr_ptr_d = 1'b0;
`endif
    end

    // Output logic; writes to x0 are consumed with the write enable kept low.
    always_comb begin
        wb.o_s0_ready = gnt0;
        wb.o_s1_ready = gnt1;
        wb.o_busy     = (stage_q == STG_FULL);
        wb.o_rd_wen   = (stage_q == STG_FULL) && (addr_q != 5'd0) && !wb.i_hold;
        wb.o_rd_waddr = addr_q;
        wb.o_rd_wdata = data_q;
        o_dbg_cnt     = cnt_q;
        o_dbg_rr_ptr  = rr_ptr_q;
        o_dbg_stage   = stage_q;
    end

endmodule
